// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: BTB entry layout,
// saturating-counter constants and PC index/tag slicing.
package bp_pkg;

    localparam int BP_XLEN = 32;

    // Tag is held right-aligned and zero-extended so one layout serves any BTB depth.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        logic               is_jump;
    } btb_entry_t;

    function automatic int cnt_reset_val(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int cnt_max_val(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic int cnt_taken_thr(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic logic [BP_XLEN-1:0] btb_tag(input logic [BP_XLEN-1:0] pc,
                                                   input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

    function automatic logic [BP_XLEN-1:0] btb_index(input logic [BP_XLEN-1:0] pc,
                                                     input int idx_w);
        return (pc >> 2) & ((BP_XLEN'(1) << idx_w) - BP_XLEN'(1));
    endfunction

    function automatic logic [BP_XLEN-1:0] pht_index(input logic [BP_XLEN-1:0] pc,
                                                     input logic [BP_XLEN-1:0] ghr,
                                                     input int ghr_w);
        return ((pc >> 2) ^ ghr) & ((BP_XLEN'(1) << ghr_w) - BP_XLEN'(1));
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch lookup and EX update bundle between the pipeline and the branch predictor.
interface gshare_branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 5
);
    // Lookup is a pure combinational query qualified by if_advance; upd_valid marks a
    // one-cycle update that is always accepted (no ready, no backpressure).
    logic [XLEN-1:0]  if_pc;
    logic             if_advance;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_next_pc;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_mispredict;
    logic [31:0]      mispredict_count;

    modport master (
        output if_pc, if_advance,
        output upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_ghr, upd_mispredict,
        input  pred_taken, pred_next_pc, pred_ghr, mispredict_count
    );

    modport slave (
        input  if_pc, if_advance,
        input  upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_ghr, upd_mispredict,
        output pred_taken, pred_next_pc, pred_ghr, mispredict_count
    );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one synchronous
// write port; reset clears only the valid bits.
module bp_btb
    import bp_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);
    localparam int DEPTH = 1 << IDX_W;

    btb_entry_t mem_q [DEPTH];

    // No write-to-read bypass: a same-cycle lookup sees the old entry.
    assign rd_entry = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage predictor: BTB for targets, gshare PHT of saturating counters for
// conditional direction, speculative GHR repaired from EX on mispredict.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = BP_XLEN,
    parameter int BTB_IDX_W = 5,
    parameter int GHR_W     = 5,
    parameter int CNT_W     = 2
) (
    input logic                 clk,
    input logic                 reset,
    gshare_branch_predictor_if.slave bp
);
    localparam int PHT_N = 1 << GHR_W;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(cnt_taken_thr(CNT_W));

    logic [GHR_W-1:0]     ghr_q;
    logic [CNT_W-1:0]     pht_q [PHT_N];
    logic [31:0]          mispredict_q;

    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_IDX_W-1:0] wr_idx;
    btb_entry_t           rd_entry;
    btb_entry_t           wr_entry;
    logic                 wr_en;

    logic                 hit;
    logic                 pred_taken;
    logic [GHR_W-1:0]     lk_pht_idx;
    logic [CNT_W-1:0]     lk_cnt;
    logic [GHR_W-1:0]     up_pht_idx;
    logic [CNT_W-1:0]     up_cnt;
    logic                 restore;
    logic                 spec_shift;
    logic                 pht_upd;

    bp_btb #(.IDX_W(BTB_IDX_W)) u_btb (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_entry (wr_entry)
    );

    always_comb begin
        rd_idx     = BTB_IDX_W'(btb_index(bp.if_pc, BTB_IDX_W));
        hit        = rd_entry.valid && (rd_entry.tag == btb_tag(bp.if_pc, BTB_IDX_W));
        lk_pht_idx = GHR_W'(pht_index(bp.if_pc, BP_XLEN'(ghr_q), GHR_W));
        lk_cnt     = pht_q[lk_pht_idx];
        pred_taken = hit && (rd_entry.is_jump || (lk_cnt >= CNT_THR));
    end

    assign bp.pred_taken       = pred_taken;
    assign bp.pred_next_pc     = pred_taken ? rd_entry.target : bp.if_pc + XLEN'(4);
    assign bp.pred_ghr         = ghr_q;
    assign bp.mispredict_count = mispredict_q;

    always_comb begin
        restore    = bp.upd_valid && bp.upd_mispredict;
        spec_shift = bp.if_advance && hit && !rd_entry.is_jump;
        pht_upd    = bp.upd_valid && !bp.upd_is_jump;
        up_pht_idx = GHR_W'(pht_index(bp.upd_pc, BP_XLEN'(bp.upd_ghr), GHR_W));
        up_cnt     = pht_q[up_pht_idx];
        wr_en      = bp.upd_valid && bp.upd_taken;
        wr_idx     = BTB_IDX_W'(btb_index(bp.upd_pc, BTB_IDX_W));
        wr_entry   = '{valid:   1'b1,
                       tag:     btb_tag(bp.upd_pc, BTB_IDX_W),
                       target:  bp.upd_target,
                       is_jump: bp.upd_is_jump};
    end

    // A mispredict restore outranks the speculative shift: that fetch is being flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q        <= '0;
            mispredict_q <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= CNT_RST;
            end
        end else begin
            if (restore) begin
                ghr_q <= bp.upd_is_jump ? bp.upd_ghr : {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
            end else if (spec_shift) begin
                ghr_q <= {ghr_q[GHR_W-2:0], pred_taken};
            end

            if (pht_upd) begin
                if (bp.upd_taken && (up_cnt != CNT_MAX)) begin
                    pht_q[up_pht_idx] <= up_cnt + CNT_W'(1);
                end else if (!bp.upd_taken && (up_cnt != '0)) begin
                    pht_q[up_pht_idx] <= up_cnt - CNT_W'(1);
                end
            end

            if (restore && (mispredict_q != '1)) begin
                mispredict_q <= mispredict_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: expected lookups are queued as they are
// driven and checked against the combinational outputs in the same cycle.
module tb_gshare_branch_predictor;
    localparam int XLEN      = 32;
    localparam int BTB_IDX_W = 5;
    localparam int GHR_W     = 5;
    localparam int CNT_W     = 2;
    localparam int EW        = 1 + XLEN + GHR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.XLEN(XLEN), .GHR_W(GHR_W)) bp ();

    gshare_branch_predictor #(
        .XLEN      (XLEN),
        .BTB_IDX_W (BTB_IDX_W),
        .GHR_W     (GHR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp.if_pc          = '0;
        bp.if_advance     = 1'b0;
        bp.upd_valid      = 1'b0;
        bp.upd_pc         = '0;
        bp.upd_is_jump    = 1'b0;
        bp.upd_taken      = 1'b0;
        bp.upd_target     = '0;
        bp.upd_ghr        = '0;
        bp.upd_mispredict = 1'b0;
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input logic is_jump, input logic taken,
                       input logic [XLEN-1:0] target, input logic [GHR_W-1:0] ghr,
                       input logic mis);
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = pc;
        bp.upd_is_jump    = is_jump;
        bp.upd_taken      = taken;
        bp.upd_target     = target;
        bp.upd_ghr        = ghr;
        bp.upd_mispredict = mis;
    endtask

    task automatic upd_clear();
        bp.upd_valid      = 1'b0;
        bp.upd_mispredict = 1'b0;
    endtask

    task automatic check_pred(input string tag);
        logic [EW-1:0] e;
        logic [EW-1:0] o;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=no_expectation expected=queued_entry", tag);
        end else begin
            e = exp_q.pop_front();
            o = {bp.pred_taken, bp.pred_next_pc, bp.pred_ghr};
            assert (o === e) else begin
                bad++;
                $error("FAIL %s observed taken=%0b next=%h ghr=%b expected taken=%0b next=%h ghr=%b",
                       tag, o[EW-1], o[EW-2:GHR_W], o[GHR_W-1:0],
                       e[EW-1], e[EW-2:GHR_W], e[GHR_W-1:0]);
            end
        end
    endtask

    task automatic lookup(input string tag, input logic [XLEN-1:0] pc, input logic adv,
                          input logic exp_taken, input logic [XLEN-1:0] exp_next,
                          input logic [GHR_W-1:0] exp_ghr);
        bp.if_pc      = pc;
        bp.if_advance = adv;
        exp_q.push_back({exp_taken, exp_next, exp_ghr});
        #1;
        check_pred(tag);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
        total++;
        assert (bp.mispredict_count === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, bp.mispredict_count, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        lookup("rst_lookup", 32'h40, 1'b0, 1'b0, 32'h44, 5'b00000);
        check_cnt("rst_cnt", 32'd0);

        // Jump allocate; same-cycle lookup must still see the old (empty) entry.
        upd(32'h40, 1'b1, 1'b1, 32'h100, 5'b00000, 1'b1);
        lookup("same_cycle_no_bypass", 32'h40, 1'b0, 1'b0, 32'h44, 5'b00000);
        tick();
        upd_clear();
        lookup("jump_hit", 32'h40, 1'b0, 1'b1, 32'h100, 5'b00000);
        check_cnt("cnt_after_jump", 32'd1);

        // Conditional branch training at index 0, ghr held at 0.
        upd(32'h80, 1'b0, 1'b1, 32'h20, 5'b00000, 1'b0);
        tick();
        upd_clear();
        lookup("cond_taken_10", 32'h80, 1'b0, 1'b1, 32'h20, 5'b00000);
        upd(32'h80, 1'b0, 1'b0, 32'h20, 5'b00000, 1'b0);
        tick();
        lookup("cond_nt_01", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00000);
        tick();
        lookup("cond_nt_00", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00000);
        tick();
        lookup("cond_nt_sat", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00000);
        upd(32'h80, 1'b0, 1'b1, 32'h20, 5'b00000, 1'b0);
        tick();
        lookup("cond_sat_then_t", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00000);
        tick();
        lookup("cond_t_again", 32'h80, 1'b0, 1'b1, 32'h20, 5'b00000);
        upd_clear();
        check_cnt("cnt_no_mispredict", 32'd1);

        // Jump restore loads GHR directly, then a speculative not-taken shift.
        upd(32'h40, 1'b1, 1'b1, 32'h100, 5'b00011, 1'b1);
        tick();
        upd_clear();
        lookup("ghr_restore_jump", 32'h40, 1'b0, 1'b1, 32'h100, 5'b00011);
        lookup("spec_lookup", 32'h80, 1'b1, 1'b0, 32'h84, 5'b00011);
        tick();
        bp.if_advance = 1'b0;
        lookup("spec_shift", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00110);

        // Restore and speculative shift in the same cycle: restore wins.
        upd(32'h40, 1'b1, 1'b1, 32'h100, 5'b00011, 1'b1);
        tick();
        upd_clear();
        lookup("ghr_set_again", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00011);
        upd(32'h80, 1'b0, 1'b0, 32'h20, 5'b00101, 1'b1);
        lookup("restore_cycle", 32'h80, 1'b1, 1'b0, 32'h84, 5'b00011);
        tick();
        upd_clear();
        bp.if_advance = 1'b0;
        lookup("restore_wins", 32'h80, 1'b0, 1'b0, 32'h84, 5'b01010);
        check_cnt("cnt_after_restore", 32'd4);

        // Tag mismatch at an occupied index: miss, no speculative shift.
        lookup("miss_adv", 32'h200, 1'b1, 1'b0, 32'h204, 5'b01010);
        tick();
        bp.if_advance = 1'b0;
        lookup("miss_no_shift", 32'h200, 1'b0, 1'b0, 32'h204, 5'b01010);
        lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 5'b01010);

        // Fill more entries, then reset mid-stream with a live update.
        upd(32'h44, 1'b1, 1'b1, 32'h344, 5'b00000, 1'b0);
        tick();
        upd(32'h48, 1'b1, 1'b1, 32'h348, 5'b00000, 1'b0);
        tick();
        upd_clear();
        lookup("fill_hit", 32'h48, 1'b0, 1'b1, 32'h348, 5'b01010);
        upd(32'h50, 1'b1, 1'b1, 32'h500, 5'b00000, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        upd_clear();
        lookup("post_rst_40", 32'h40, 1'b0, 1'b0, 32'h44, 5'b00000);
        lookup("post_rst_44", 32'h44, 1'b0, 1'b0, 32'h48, 5'b00000);
        lookup("post_rst_48", 32'h48, 1'b0, 1'b0, 32'h4C, 5'b00000);
        lookup("post_rst_80", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00000);
        lookup("post_rst_50_lost", 32'h50, 1'b0, 1'b0, 32'h54, 5'b00000);
        check_cnt("post_rst_cnt", 32'd0);

        // PHT back at weakly not-taken: one taken then one not-taken predicts not-taken.
        upd(32'h80, 1'b0, 1'b1, 32'h20, 5'b00000, 1'b0);
        tick();
        upd_clear();
        lookup("pht_rst_t", 32'h80, 1'b0, 1'b1, 32'h20, 5'b00000);
        upd(32'h80, 1'b0, 1'b0, 32'h20, 5'b00000, 1'b0);
        tick();
        upd_clear();
        lookup("pht_rst_nt", 32'h80, 1'b0, 1'b0, 32'h84, 5'b00000);

        // Preload the counter near its ceiling, then saturate it.
        force dut.mispredict_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_q;
        check_cnt("sat_preload", 32'hFFFF_FFFE);
        upd(32'h40, 1'b1, 1'b1, 32'h100, 5'b00000, 1'b1);
        tick();
        check_cnt("sat_reach", 32'hFFFF_FFFF);
        tick();
        check_cnt("sat_hold", 32'hFFFF_FFFF);
        upd_clear();
        tick();
        check_cnt("sat_idle_hold", 32'hFFFF_FFFF);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
